// File: rtl/puf_tune_if.sv
// puf_tune_if: start/done handshake and PUF evaluation bus between BIST, tuner and arbiter.
interface puf_tune_if #(parameter int K = 5, parameter int WIN_LOG2 = 8);
  logic start, eval_req, resp_valid, resp, busy, done, locked, timeout;
  logic [K-1:0] tune_level;
  logic [WIN_LOG2:0] ones_cnt;
  modport master (output start, resp_valid, resp,
                  input eval_req, tune_level, busy, done, locked, timeout, ones_cnt);
  modport slave (input start, resp_valid, resp,
                 output eval_req, tune_level, busy, done, locked, timeout, ones_cnt);
endinterface

// File: rtl/puf_tune_ctrl.sv
// puf_tune_ctrl: binary-search bias tuner driving tune_level until PUF ones-ratio is within MARGIN of 50%.
// Define PUF_TUNE_TIMEOUT_EN to bound each WAIT by TIMEOUT cycles (abort with timeout flag).
module puf_tune_ctrl #(
  parameter int K        = 5,
  parameter int WIN_LOG2 = 8,
  parameter int MARGIN   = 8,
  parameter int SETTLE   = 4,
  parameter int TIMEOUT  = 1024
) (
  input logic clk,
  input logic rst,
  puf_tune_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_SETL, S_REQ, S_WAIT, S_DECIDE, S_FIN} state_t;
  localparam int H  = 2 ** (WIN_LOG2 - 1);
  localparam int SW = $clog2(SETTLE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [K-1:0] LVL0 = K'(2 ** (K - 1));
  localparam logic [K-1:0] STEP0 = K'(2 ** (K - 2));
  localparam logic [WIN_LOG2:0] HI = (WIN_LOG2 + 1)'(H + MARGIN);
  localparam logic [WIN_LOG2:0] LO = (WIN_LOG2 + 1)'(H - MARGIN);
  state_t state_q, state_d;
  logic [K-1:0] level_q, level_d, step_q, step_d;
  logic [WIN_LOG2:0] acc_q, acc_d, ones_q, ones_d;
  logic [WIN_LOG2-1:0] cnt_q, cnt_d;
  logic [SW-1:0] set_q, set_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic locked_q, locked_d, timeout_q, timeout_d;
  logic [K:0] delta, up, dn;
  logic off_bias;
  // once the step reaches 0 the last window re-checks with a +/-1 move
  assign delta = (step_q == '0) ? (K + 1)'(1) : {1'b0, step_q};
  assign up = {1'b0, level_q} + delta;
  assign dn = {1'b0, level_q} - delta;
  assign off_bias = (acc_q > HI) || (acc_q < LO);
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    step_d = step_q;
    acc_d = acc_q;
    ones_d = ones_q;
    cnt_d = cnt_q;
    set_d = set_q;
    tmo_d = tmo_q;
    locked_d = locked_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE: if (bus.start) begin
        state_d = S_SETL;
        level_d = LVL0;
        step_d = STEP0;
        acc_d = '0;
        cnt_d = '0;
        set_d = '0;
        tmo_d = '0;
        locked_d = 1'b0;
        timeout_d = 1'b0;
      end
      S_SETL: begin
        set_d = (set_q == SW'(SETTLE - 1)) ? '0 : set_q + SW'(1);
        state_d = (set_q == SW'(SETTLE - 1)) ? S_REQ : S_SETL;
      end
      S_REQ: begin
        tmo_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.resp_valid) begin
          acc_d = acc_q + {{WIN_LOG2{1'b0}}, bus.resp};
          cnt_d = cnt_q + WIN_LOG2'(1);
          state_d = (cnt_q == '1) ? S_DECIDE : S_REQ;
        end
`ifdef PUF_TUNE_TIMEOUT_EN
        else if (tmo_q == TW'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          locked_d = 1'b0;
          state_d = S_FIN;
        end else tmo_d = tmo_q + TW'(1);
`endif
      end
      S_DECIDE: begin
        ones_d = acc_q;
        acc_d = '0;
        step_d = step_q >> 1;
        if (acc_q > HI) level_d = dn[K] ? '0 : dn[K-1:0];
        else if (acc_q < LO) level_d = up[K] ? '1 : up[K-1:0];
        else locked_d = 1'b1;
        state_d = (off_bias && step_q != '0) ? S_SETL : S_FIN;
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_IDLE;
      level_q <= LVL0;
      step_q <= STEP0;
      acc_q <= '0;
      ones_q <= '0;
      cnt_q <= '0;
      set_q <= '0;
      tmo_q <= '0;
      locked_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      step_q <= step_d;
      acc_q <= acc_d;
      ones_q <= ones_d;
      cnt_q <= cnt_d;
      set_q <= set_d;
      tmo_q <= tmo_d;
      locked_q <= locked_d;
      timeout_q <= timeout_d;
    end
  assign bus.eval_req = state_q == S_REQ;
  assign bus.busy = state_q != S_IDLE && state_q != S_FIN;
  assign bus.done = state_q == S_FIN;
  assign bus.tune_level = level_q;
  assign bus.locked = locked_q;
  assign bus.timeout = timeout_q;
  assign bus.ones_cnt = ones_q;
endmodule

// File: tb/tb_puf_tune_ctrl.sv
// tb_puf_tune_ctrl: randomized closed-loop bench for puf_tune_ctrl with a window-level reference model.
module tb_puf_tune_ctrl;
  localparam int K = 5, WL = 8, MARGIN = 8, SETTLE = 4, TIMEOUT = 1024;
  localparam int WIN = 2 ** WL, H = WIN / 2, LMAX = 2 ** K - 1;
`ifdef PUF_TUNE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  int n_cmp = 0, n_bad = 0;
  int mode = 0, n_req = 0, pend = 0;
  bit alt = 1'b0, stray = 1'b0;
  int lv_q[$];
  int exp3[5] = '{16, 8, 4, 2, 1};
  bit m_run, m_wait, m_reqp, m_dec, m_donep, m_lk, m_to, m_nlk, m_nfin, e_done, e_req, idle, acc;
  int m_lvl, m_step, m_ones, m_wo, m_wn, m_req_cd, m_to_cd, m_nlvl, m_nones, d;

  puf_tune_if #(.K(K), .WIN_LOG2(WL)) bus ();
  puf_tune_ctrl #(.K(K), .WIN_LOG2(WL), .MARGIN(MARGIN), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT))
    dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit gen_bit();
    if (mode == 0) begin
      alt = ~alt;
      return alt;
    end
    if (mode == 1) return 1'b1;
    return $urandom_range(30, 0) < bus.tune_level;
  endfunction

  // PUF/arbiter stand-in: one response 1..3 cycles after each request
  initial begin
    bus.resp_valid = 1'b0;
    bus.resp = 1'b0;
    forever begin
      @(negedge clk);
      bus.resp_valid = 1'b0;
      if (stray) begin
        bus.resp_valid = 1'b1;
        bus.resp = 1'b1;
        stray = 1'b0;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0 && mode != 3) begin
          bus.resp_valid = 1'b1;
          bus.resp = gen_bit();
        end
      end
      if (bus.eval_req) begin
        n_req++;
        if (lv_q.size() == 0 || lv_q[$] != int'(bus.tune_level)) lv_q.push_back(int'(bus.tune_level));
        pend = $urandom_range(3, 1);
      end
    end
  end

  // Reference model: windows of accepted responses drive the search; outputs compared every cycle
  initial forever begin
    @(posedge clk);
    #1;
    if (rst) begin
      m_run = 0; m_wait = 0; m_reqp = 0; m_dec = 0; m_donep = 0; m_lk = 0; m_to = 0;
      m_lvl = 16; m_ones = 0; m_wo = 0; m_wn = 0; m_req_cd = 0; m_to_cd = 0;
      e_done = 0; e_req = 0;
    end else begin
      idle = !m_run && !m_donep;
      acc = bus.resp_valid && m_wait;
      if (m_reqp) m_wait = 1;
      e_done = 0;
      e_req = 0;
      if (m_req_cd > 0) begin
        m_req_cd--;
        e_req = (m_req_cd == 0);
      end
      if (m_dec) begin
        m_dec = 0;
        m_lvl = m_nlvl;
        m_ones = m_nones;
        m_lk = m_nlk;
        if (m_nfin) e_done = 1;
        else m_req_cd = SETTLE;
      end
      if (acc) begin
        m_wait = 0;
        m_to_cd = 0;
        m_wo += int'(bus.resp);
        m_wn++;
        if (m_wn == WIN) begin
          d = (m_step == 0) ? 1 : m_step;
          m_nones = m_wo;
          m_nlk = 0;
          m_nfin = (m_step == 0);
          m_nlvl = m_lvl;
          if (m_wo > H + MARGIN) m_nlvl = (m_lvl - d < 0) ? 0 : m_lvl - d;
          else if (m_wo < H - MARGIN) m_nlvl = (m_lvl + d > LMAX) ? LMAX : m_lvl + d;
          else begin
            m_nlk = 1;
            m_nfin = 1;
          end
          m_step = m_step / 2;
          m_wo = 0;
          m_wn = 0;
          m_dec = 1;
        end else e_req = 1;
      end
      if (m_to_cd > 0) begin
        m_to_cd--;
        if (m_to_cd == 0) begin
          e_done = 1;
          m_to = 1;
          m_lk = 0;
          m_wait = 0;
        end
      end
      if (e_done) m_run = 0;
      if (idle && bus.start) begin
        m_run = 1; m_lvl = 16; m_step = 8; m_wo = 0; m_wn = 0; m_lk = 0; m_to = 0;
        m_req_cd = SETTLE;
      end
      if (e_req) m_to_cd = TO_EN ? TIMEOUT + 1 : 0;
      m_reqp = e_req;
      m_donep = e_done;
    end
    chk("busy", int'(bus.busy), int'(m_run));
    chk("done", int'(bus.done), int'(e_done));
    chk("eval_req", int'(bus.eval_req), int'(e_req));
    chk("tune_level", int'(bus.tune_level), m_lvl);
    chk("locked", int'(bus.locked), int'(m_lk));
    chk("timeout", int'(bus.timeout), int'(m_to));
    chk("ones_cnt", int'(bus.ones_cnt), m_ones);
  end

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    for (int i = 0; i < budget && !bus.done; i++) @(negedge clk);
    chk(nm, int'(bus.done), 1);
  endtask

  initial begin
    int snap;
    rst = 1'b1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    // reset in the middle of a window
    mode = 1;
    n_req = 0;
    pulse_start();
    for (int i = 0; i < 2000 && n_req < 3; i++) @(negedge clk);
    chk("t1_reqs_seen", int'(n_req >= 3), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t1_level", int'(bus.tune_level), 16);
    chk("t1_busy", int'(bus.busy), 0);
    rst = 1'b0;
    snap = n_req;
    repeat (20) @(negedge clk);
    chk("t1_no_req", n_req, snap);
    // balanced responses lock on the first window
    mode = 0;
    alt = 1'b0;
    n_req = 0;
    pulse_start();
    wait_done("t2_done", 3 * WIN * 5);
    chk("t2_reqs", n_req, WIN);
    chk("t2_ones", int'(bus.ones_cnt), 128);
    chk("t2_locked", int'(bus.locked), 1);
    chk("t2_level", int'(bus.tune_level), 16);
    // all-ones responses walk the level down to 0
    mode = 1;
    n_req = 0;
    lv_q.delete();
    pulse_start();
    wait_done("t3_done", 6 * WIN * 5);
    chk("t3_nlevels", lv_q.size(), 5);
    for (int i = 0; i < 5 && i < lv_q.size(); i++) chk("t3_level_seq", lv_q[i], exp3[i]);
    chk("t3_level", int'(bus.tune_level), 0);
    chk("t3_ones", int'(bus.ones_cnt), 256);
    chk("t3_locked", int'(bus.locked), 0);
    chk("t3_reqs", n_req, 5 * WIN);
    // level-dependent random PUF
    for (int r = 0; r < 3; r++) begin
      mode = 2;
      n_req = 0;
      pulse_start();
      wait_done("t4_done", 6 * WIN * 5);
      chk("t4_windows", int'(n_req <= K * WIN), 1);
      chk("t4_level_range", int'(bus.tune_level >= 8 && bus.tune_level <= 24), 1);
      if (bus.locked) chk("t4_lock_bias", int'(bus.ones_cnt >= H - MARGIN && bus.ones_cnt <= H + MARGIN), 1);
    end
    // stray response in SETTLE and start while busy are both ignored
    mode = 0;
    alt = 1'b0;
    n_req = 0;
    pulse_start();
    stray = 1'b1;
    for (int i = 0; i < 2000 && n_req < 50; i++) @(negedge clk);
    pulse_start();
    wait_done("t5_done", 3 * WIN * 5);
    chk("t5_reqs", n_req, WIN);
    chk("t5_ones", int'(bus.ones_cnt), 128);
    chk("t5_locked", int'(bus.locked), 1);
    // silent PUF
    mode = 3;
    n_req = 0;
    pulse_start();
    if (TO_EN) begin
      wait_done("t6_done", TIMEOUT + 100);
      chk("t6_timeout", int'(bus.timeout), 1);
      chk("t6_locked", int'(bus.locked), 0);
      chk("t6_reqs", n_req, 1);
    end else begin
      repeat (TIMEOUT + 100) @(negedge clk);
      chk("t6_busy", int'(bus.busy), 1);
      chk("t6_reqs", n_req, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: simulation did not finish within budget");
    $fatal(1, "watchdog");
  end
endmodule
